// File: rtl/jk_drive_pkg.sv
// Shared types for the JK command sequencer: command opcodes, FSM states and
// the JK next-state rule used by the shadow model.
package jk_drive_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11:   nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_drive_seq_if.sv
// Command channel into the JK sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the master holds cmd_op/cmd_len stable while cmd_valid is high and not yet accepted.
interface jk_drive_seq_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits, pointers wrap naturally.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/jk_drive_seq.sv
// Plays queued HOLD/CLR/SET/TOGGLE commands onto registered j/k for len cycles,
// with a shadow q model; the q_fb comparator is built only with JK_CHECK_EN.
module jk_drive_seq
  import jk_drive_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  jk_drive_seq_if.slave       cmd,
  output logic                j,
  output logic                k,
  input  logic                q_fb,
  output logic                busy,
  output logic                done,
  output logic                q_exp,
  output logic                err,
  input  logic                err_clr,
  output state_e              dbg_state
);
  localparam int W = 2 + LEN_W;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             j_q, k_q, j_d, k_d;
  logic             done_q, done_d;
  logic             qexp_q;

  logic             push, pop, full, empty;
  logic [W-1:0]     fifo_rdata;
  logic [1:0]       fifo_op;
  logic [LEN_W-1:0] fifo_len, fifo_len_eff;
  logic [$clog2(DEPTH):0] fifo_count;

  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign fifo_op       = fifo_rdata[W-1 -: 2];
  assign fifo_len      = fifo_rdata[LEN_W-1:0];
  assign fifo_len_eff  = (fifo_len == '0) ? LEN_ONE : fifo_len;

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({cmd.cmd_op, cmd.cmd_len}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // The next command is popped on the last drive cycle so back-to-back commands leave no bubble.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    j_d     = 1'b0;
    k_d     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          op_d    = fifo_op;
          cnt_d   = fifo_len_eff;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        j_d = op_q[1];
        k_d = op_q[0];
        if (cnt_q == LEN_ONE) begin
          done_d = 1'b1;
          if (!empty) begin
            pop   = 1'b1;
            op_d  = fifo_op;
            cnt_d = fifo_len_eff;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - LEN_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= LEN_ONE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      qexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      qexp_q  <= jk_next(qexp_q, j_q, k_q);
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign q_exp     = qexp_q;
  assign busy      = (state_q == ST_ISSUE) || (fifo_count != '0);
  assign dbg_state = state_q;

`ifdef JK_CHECK_EN
  logic chk_en_q, err_q;

  // A mismatch outranks err_clr so a fault seen while clearing is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chk_en_q <= 1'b1;
      if (chk_en_q && (q_fb != qexp_q)) err_q <= 1'b1;
      else if (err_clr)                 err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{q_fb, err_clr};
  assign err        = 1'b0;
`endif

endmodule
